// File: rtl/axil_m_wrap.sv
// AXI4-Lite master: runs one register read or write command at a time on the bus
// and returns the response (and read data) on a valid/ready response port.
module axil_m_wrap #(
    parameter int C_M_AXI_DATA_WIDTH = 64,
    parameter int C_M_AXI_ADDR_WIDTH = 32
) (
    input  logic                              clk,
    input  logic                              rst,

    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic                              cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,

    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic                              rsp_write,
    output logic [1:0]                        rsp_resp,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axil_awaddr,
    output logic [2:0]                        m_axil_awprot,
    output logic                              m_axil_awvalid,
    input  logic                              m_axil_awready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     m_axil_wdata,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   m_axil_wstrb,
    output logic                              m_axil_wvalid,
    input  logic                              m_axil_wready,
    input  logic [1:0]                        m_axil_bresp,
    input  logic                              m_axil_bvalid,
    output logic                              m_axil_bready,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axil_araddr,
    output logic [2:0]                        m_axil_arprot,
    output logic                              m_axil_arvalid,
    input  logic                              m_axil_arready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     m_axil_rdata,
    input  logic [1:0]                        m_axil_rresp,
    input  logic                              m_axil_rvalid,
    output logic                              m_axil_rready,

    output logic [2:0]                        dbg_state_o
);

    localparam int SW = C_M_AXI_DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        WR_ADDR_DATA = 3'd1,
        WR_RESP      = 3'd2,
        RD_ADDR      = 3'd3,
        RD_DATA      = 3'd4,
        RSP          = 3'd5
    } state_t;

    state_t                          state_q, state_d;
    logic                            aw_done_q, aw_done_d;
    logic                            w_done_q, w_done_d;
    logic                            awvalid_q, awvalid_d;
    logic                            wvalid_q, wvalid_d;
    logic                            bready_q, bready_d;
    logic                            arvalid_q, arvalid_d;
    logic                            rready_q, rready_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [SW-1:0]                   wstrb_q, wstrb_d;
    logic                            rsp_write_q, rsp_write_d;
    logic [1:0]                      rsp_resp_q, rsp_resp_d;
    logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                            aw_hs, w_hs;

    // Handshake rule on every channel: a beat transfers on a rising clk edge where
    // valid and ready are both high; valid never waits for ready and payload holds until then.
    assign aw_hs = awvalid_q & m_axil_awready;
    assign w_hs  = wvalid_q & m_axil_wready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rsp_write_q <= 1'b0;
            rsp_resp_q  <= 2'b00;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rsp_write_q <= rsp_write_d;
            rsp_resp_q  <= rsp_resp_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        rsp_write_d = rsp_write_q;
        rsp_resp_d  = rsp_resp_q;
        rsp_rdata_d = rsp_rdata_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    wstrb_d = cmd_wstrb;
                    if (cmd_write) begin
                        state_d   = WR_ADDR_DATA;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                    end else begin
                        state_d   = RD_ADDR;
                        arvalid_d = 1'b1;
                    end
                end
            end
            WR_ADDR_DATA: begin
                // AW and W retire independently; either may finish first or both together.
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
                    state_d   = WR_RESP;
                    bready_d  = 1'b1;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            WR_RESP: begin
                if (m_axil_bvalid) begin
                    state_d     = RSP;
                    bready_d    = 1'b0;
                    rsp_write_d = 1'b1;
                    rsp_resp_d  = m_axil_bresp;
                    rsp_rdata_d = '0;
                end
            end
            RD_ADDR: begin
                if (m_axil_arready) begin
                    state_d   = RD_DATA;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            RD_DATA: begin
                if (m_axil_rvalid) begin
                    state_d     = RSP;
                    rready_d    = 1'b0;
                    rsp_write_d = 1'b0;
                    rsp_resp_d  = m_axil_rresp;
                    rsp_rdata_d = m_axil_rdata;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake outputs are masked while rst is high so nothing looks live in the reset cycle.
    assign cmd_ready      = (state_q == IDLE) & ~rst;
    assign rsp_valid      = (state_q == RSP) & ~rst;
    assign rsp_write      = rsp_write_q;
    assign rsp_resp       = rsp_resp_q;
    assign rsp_rdata      = rsp_rdata_q;

    assign m_axil_awaddr  = addr_q;
    assign m_axil_awprot  = 3'b000;
    assign m_axil_awvalid = awvalid_q & ~rst;
    assign m_axil_wdata   = wdata_q;
    assign m_axil_wstrb   = wstrb_q;
    assign m_axil_wvalid  = wvalid_q & ~rst;
    assign m_axil_bready  = bready_q & ~rst;
    assign m_axil_araddr  = addr_q;
    assign m_axil_arprot  = 3'b000;
    assign m_axil_arvalid = arvalid_q & ~rst;
    assign m_axil_rready  = rready_q & ~rst;

    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_axil_m_wrap.sv
// Directed bench for axil_m_wrap: an AXI-Lite slave model with programmable
// ready/valid delays, a response scoreboard and cycle-exact timing checks.
module tb_axil_m_wrap;

    localparam int DW = 64;
    localparam int AW = 32;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [SW-1:0] cmd_wstrb;
    logic          rsp_valid, rsp_ready, rsp_write;
    logic [1:0]    rsp_resp;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] awaddr, araddr;
    logic [2:0]    awprot, arprot;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rvalid, rready;
    logic [DW-1:0] wdata, rdata;
    logic [SW-1:0] wstrb;
    logic [1:0]    bresp, rresp;
    logic [2:0]    dbg_state;

    axil_m_wrap #(.C_M_AXI_DATA_WIDTH(DW), .C_M_AXI_ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_resp(rsp_resp), .rsp_rdata(rsp_rdata),
        .m_axil_awaddr(awaddr), .m_axil_awprot(awprot), .m_axil_awvalid(awvalid),
        .m_axil_awready(awready), .m_axil_wdata(wdata), .m_axil_wstrb(wstrb),
        .m_axil_wvalid(wvalid), .m_axil_wready(wready), .m_axil_bresp(bresp),
        .m_axil_bvalid(bvalid), .m_axil_bready(bready), .m_axil_araddr(araddr),
        .m_axil_arprot(arprot), .m_axil_arvalid(arvalid), .m_axil_arready(arready),
        .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid),
        .m_axil_rready(rready), .dbg_state_o(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    int total = 0;
    int bad = 0;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // ---------------- slave model ----------------
    int         aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic [1:0] b_resp_v = 2'b00, r_resp_v = 2'b00;
    logic [DW-1:0] mem [8];

    initial begin
        int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
        logic aw_got, w_got, b_pend, r_pend;
        logic [AW-1:0] aw_l, ar_l;
        logic [DW-1:0] wd_l;
        logic [SW-1:0] ws_l;
        for (int i = 0; i < 8; i++) mem[i] = '0;
        mem[3] = 64'h0000_0000_CAFE_F00D;
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
        aw_l = 0; ar_l = 0; wd_l = 0; ws_l = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
                aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
                aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
            end else begin
                bvalid = 0; bresp = 0;
                if (b_pend) begin
                    if (b_cnt >= b_dly) begin
                        bvalid = 1; bresp = b_resp_v;
                        if (bready) b_pend = 0;
                    end else b_cnt++;
                end
                rvalid = 0; rdata = 0; rresp = 0;
                if (r_pend) begin
                    if (r_cnt >= r_dly) begin
                        rvalid = 1; rdata = mem[ar_l[5:3]]; rresp = r_resp_v;
                        if (rready) r_pend = 0;
                    end else r_cnt++;
                end
                awready = 0;
                if (awvalid && !aw_got) begin
                    if (aw_cnt >= aw_dly) begin awready = 1; aw_got = 1; aw_l = awaddr; end
                    else aw_cnt++;
                end
                wready = 0;
                if (wvalid && !w_got) begin
                    if (w_cnt >= w_dly) begin wready = 1; w_got = 1; wd_l = wdata; ws_l = wstrb; end
                    else w_cnt++;
                end
                if (aw_got && w_got) begin
                    for (int b = 0; b < SW; b++)
                        if (ws_l[b]) mem[aw_l[5:3]][8*b +: 8] = wd_l[8*b +: 8];
                    aw_got = 0; w_got = 0; aw_cnt = 0; w_cnt = 0;
                    b_pend = 1; b_cnt = 0;
                end
                arready = 0;
                if (arvalid) begin
                    if (ar_cnt >= ar_dly) begin
                        arready = 1; ar_l = araddr; r_pend = 1; r_cnt = 0; ar_cnt = 0;
                    end else ar_cnt++;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic [66:0] exp_q[$];
    int rsp_cnt = 0;

    initial begin
        logic [66:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (rsp_valid && rsp_ready) begin
                rsp_cnt++;
                if (exp_q.size() == 0) check_val("rsp_unexpected", exp_q.size(), 1);
                else begin
                    e = exp_q.pop_front();
                    check_val("rsp", {rsp_write, rsp_resp, rsp_rdata}, e);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic expect_rsp(input logic w, input logic [1:0] r, input logic [DW-1:0] d);
        exp_q.push_back({w, r, d});
    endtask

    // Presents a command, holds it until accepted, returns in the cycle after acceptance.
    task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [SW-1:0] s, output int acc);
        cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1;
        acc = -1;
        for (int t = 0; t < 40; t++) begin
            if (cmd_ready) begin acc = cyc; break; end
            tick();
        end
        check_val("cmd_accepted", 128'(acc >= 0), 1);
        tick();
        cmd_valid = 0;
    endtask

    task automatic drain();
        for (int t = 0; t < 100; t++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        check_val("drain_empty", exp_q.size(), 0);
    endtask

    // ---------------- back-to-back vectors (hand-computed read-back) ----------------
    logic          tb_w [8];
    logic [AW-1:0] tb_a [8];
    logic [DW-1:0] tb_d [8];
    logic [SW-1:0] tb_s [8];
    logic [DW-1:0] tb_e [8];

    initial begin
        tb_w[0] = 1; tb_a[0] = 32'h00; tb_d[0] = 64'h0123_4567_89AB_CDEF; tb_s[0] = 8'hFF; tb_e[0] = 0;
        tb_w[1] = 0; tb_a[1] = 32'h00; tb_d[1] = 0; tb_s[1] = 0; tb_e[1] = 64'h0123_4567_89AB_CDEF;
        tb_w[2] = 1; tb_a[2] = 32'h10; tb_d[2] = 64'hAAAA_AAAA_AAAA_AAAA; tb_s[2] = 8'h0F; tb_e[2] = 0;
        tb_w[3] = 0; tb_a[3] = 32'h10; tb_d[3] = 0; tb_s[3] = 0; tb_e[3] = 64'h0000_0000_AAAA_AAAA;
        tb_w[4] = 1; tb_a[4] = 32'h30; tb_d[4] = 64'h5555_5555_5555_5555; tb_s[4] = 8'hF0; tb_e[4] = 0;
        tb_w[5] = 0; tb_a[5] = 32'h30; tb_d[5] = 0; tb_s[5] = 0; tb_e[5] = 64'h5555_5555_0123_4567;
        tb_w[6] = 1; tb_a[6] = 32'h38; tb_d[6] = 64'hFFFF_FFFF_FFFF_FFFF; tb_s[6] = 8'h81; tb_e[6] = 0;
        tb_w[7] = 0; tb_a[7] = 32'h38; tb_d[7] = 0; tb_s[7] = 0; tb_e[7] = 64'hFF00_0000_0000_00FF;
    end

    // ---------------- main sequence ----------------
    initial begin
        int acc, prev_acc, awv_n, wv_n, first_b, unstable, rdy_n, rsp_n, first_rsp, spur;
        rst = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
        rsp_ready = 1;

        // reset state
        tick(); tick();
        check_val("rst_cmd_ready", cmd_ready, 0);
        check_val("rst_valids", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 0);
        check_val("rst_rsp_rdata", rsp_rdata, 0);
        check_val("rst_state", dbg_state, 0);
        tick();
        rst = 0;
        #1;
        check_val("post_rst_cmd_ready", cmd_ready, 1);
        check_val("prot", {awprot, arprot}, 0);
        tick();

        // write, zero-wait slave
        expect_rsp(1, 2'b00, 0);
        issue(1, 32'h30, 64'hDEAD_BEEF_0123_4567, 8'hFF, acc);
        check_val("wr_n1_valids", {awvalid, wvalid, arvalid}, 3'b110);
        check_val("wr_n1_awaddr", awaddr, 32'h30);
        check_val("wr_n1_wdata", {wstrb, wdata}, {8'hFF, 64'hDEAD_BEEF_0123_4567});
        check_val("wr_n1_cmd_ready", cmd_ready, 0);
        tick();
        check_val("wr_n2", {awvalid, wvalid, bready}, 3'b001);
        tick();
        check_val("wr_n3_rsp", {rsp_valid, rsp_write, rsp_resp, rsp_rdata}, {1'b1, 1'b1, 2'b00, 64'h0});
        tick();
        check_val("wr_n4", {rsp_valid, cmd_ready}, 2'b01);

        // read, zero-wait slave
        expect_rsp(0, 2'b00, 64'h0000_0000_CAFE_F00D);
        issue(0, 32'h18, 64'h0, 8'h0, acc);
        check_val("rd_n1", {arvalid, awvalid, wvalid}, 3'b100);
        check_val("rd_n1_araddr", araddr, 32'h18);
        tick();
        check_val("rd_n2_rready", {rready, arvalid}, 2'b10);
        tick();
        check_val("rd_n3_rsp", {rsp_valid, rsp_write, rsp_resp, rsp_rdata},
                  {1'b1, 1'b0, 2'b00, 64'h0000_0000_CAFE_F00D});
        tick();

        // skewed AW/W: awready 3 cycles late
        aw_dly = 3;
        expect_rsp(1, 2'b00, 0);
        issue(1, 32'h28, 64'h0F0F_0F0F_0F0F_0F0F, 8'hFF, acc);
        awv_n = 0; wv_n = 0; first_b = 0; unstable = 0;
        for (int k = 1; k <= 6; k++) begin
            if (k > 1) tick();
            if (k == 2) begin cmd_addr = 32'h3FC; cmd_wdata = '1; end
            awv_n += int'(awvalid);
            wv_n += int'(wvalid);
            if (awvalid && awaddr !== 32'h28) unstable++;
            if (bready && first_b == 0) first_b = k;
            if (k == 6) check_val("skew_rsp_n6", {rsp_valid, rsp_write}, 2'b11);
        end
        check_val("skew_awvalid_cycles", awv_n, 4);
        check_val("skew_wvalid_cycles", wv_n, 1);
        check_val("skew_awaddr_stable", unstable, 0);
        check_val("skew_first_bready", first_b, 5);
        aw_dly = 0;
        tick();
        check_val("skew_single_rsp", rsp_valid, 0);

        // backpressure: bvalid late with SLVERR, rsp_ready held low, second command waiting
        b_dly = 5; b_resp_v = 2'b10; rsp_ready = 0;
        expect_rsp(1, 2'b10, 0);
        issue(1, 32'h20, 64'h1111_1111_1111_1111, 8'hFF, acc);
        rdy_n = 0; rsp_n = 0; first_rsp = 0;
        for (int k = 1; k <= 11; k++) begin
            if (k > 1) tick();
            if (k == 2) begin
                cmd_write = 0; cmd_addr = 32'h18; cmd_wdata = 0; cmd_wstrb = 0; cmd_valid = 1;
            end
            rdy_n += int'(cmd_ready);
            if (rsp_valid) begin
                rsp_n++;
                if (first_rsp == 0) first_rsp = k;
                check_val("bp_rsp_payload", {rsp_write, rsp_resp}, 3'b110);
                if (rsp_n >= 4) rsp_ready = 1;
            end
        end
        check_val("bp_cmd_ready_low", rdy_n, 0);
        check_val("bp_first_rsp", first_rsp, 8);
        check_val("bp_rsp_cycles", rsp_n, 4);
        b_dly = 0; b_resp_v = 2'b00;
        tick();
        check_val("bp_second_accept", {cmd_ready, rsp_valid}, 2'b10);
        expect_rsp(0, 2'b00, 64'h0000_0000_CAFE_F00D);
        tick();
        cmd_valid = 0;
        check_val("bp_second_ar", {arvalid, araddr}, {1'b1, 32'h18});
        drain();

        // reset while waiting in RD_DATA
        r_dly = 1000;
        issue(0, 32'h08, 64'h0, 8'h0, acc);
        check_val("rr_arvalid", arvalid, 1);
        tick();
        check_val("rr_in_rd_data", {rready, dbg_state}, {1'b1, 3'd4});
        tick();
        rst = 1;
        #1;
        check_val("rr_during_rst", {rready, rsp_valid, cmd_ready}, 3'b000);
        tick();
        rst = 0;
        r_dly = 0;
        #1;
        check_val("rr_after_rst", {cmd_ready, rready, dbg_state}, {1'b1, 1'b0, 3'd0});
        spur = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            spur += int'(rsp_valid);
        end
        check_val("rr_no_spurious_rsp", spur, 0);

        // back-to-back alternating write/read, one transaction per 4 cycles
        prev_acc = 0;
        for (int i = 0; i < 8; i++) begin
            expect_rsp(tb_w[i], 2'b00, tb_e[i]);
            issue(tb_w[i], tb_a[i], tb_d[i], tb_s[i], acc);
            if (i > 0) check_val("b2b_gap", acc - prev_acc, 4);
            prev_acc = acc;
        end
        drain();

        check_val("rsp_count", rsp_cnt, 13);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axil_m_wrap.md
Name: axil_m_wrap

Overview:
- AXI4-Lite master (initiator), built as the counterpart of the team's AXI-Lite slave register wrapper.
- Accepts single register read/write commands from a local controller or testbench sequencer and runs them on an AXI4-Lite bus.
- Returns the response and read data on a valid/ready response port.
- One outstanding transaction at a time. Used to program and poll the accelerator's register bank.

Parameters:
C_M_AXI_DATA_WIDTH, 64, AXI data width in bits (multiple of 8)
C_M_AXI_ADDR_WIDTH, 32, AXI address width in bits

Ports:
clk  input  1  single clock
rst  input  1  synchronous, active-high reset
cmd_valid  input  1  command request
cmd_ready  output  1  command accepted when cmd_valid&cmd_ready
cmd_write  input  1  1=write, 0=read
cmd_addr  input  C_M_AXI_ADDR_WIDTH  byte address
cmd_wdata  input  C_M_AXI_DATA_WIDTH  write data
cmd_wstrb  input  C_M_AXI_DATA_WIDTH/8  write byte strobes
rsp_valid  output  1  response available
rsp_ready  input  1  response consumed
rsp_write  output  1  response belongs to a write
rsp_resp  output  2  BRESP or RRESP
rsp_rdata  output  C_M_AXI_DATA_WIDTH  read data (0 for writes)
m_axil_awaddr/awprot/awvalid out, awready in  ADDR/3/1/1  write address channel
m_axil_wdata/wstrb/wvalid out, wready in  DATA/DATA/8/1/1  write data channel
m_axil_bresp in, bvalid in, bready out  2/1/1  write response channel
m_axil_araddr/arprot/arvalid out, arready in  ADDR/3/1/1  read address channel
m_axil_rdata in, rresp in, rvalid in, rready out  DATA/2/1/1  read data channel

Behaviour:
- Reset: clk edge with rst=1 forces state IDLE. All valids and readies low, cmd_ready=0 in that cycle. rsp_* registers, addresses, data and strobes cleared to 0.
- Reset mid-transaction aborts immediately, with no completion on the response port. The bus is reset on the same rst.
- awprot=arprot=3'b000 always.
- FSM states: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RSP.
- IDLE:
  - cmd_ready=1, combinational from state only; never depends on cmd_valid.
  - On handshake, latch addr/wdata/wstrb/write.
  - Go to WR_ADDR_DATA with awvalid=wvalid=1, or to RD_ADDR with arvalid=1, registered so the valids are high the next cycle.
- WR_ADDR_DATA:
  - AW and W complete independently. Each valid stays high, with stable payload, until its own ready is sampled high, then drops to 0 the following cycle.
  - aw_done/w_done flags track completion. Same-cycle awready and wready is legal.
  - When both are done (including the same cycle), go to WR_RESP with bready=1.
  - Never waits on ready before asserting valid.
- WR_RESP: bready=1. On bvalid, capture bresp into rsp_resp, set rsp_write=1, rsp_rdata=0, go to RSP, bready=0.
- RD_ADDR: arvalid held with stable araddr until arready, then RD_DATA with rready=1.
- RD_DATA: on rvalid, capture rdata/rresp, set rsp_write=0, go to RSP, rready=0.
- RSP:
  - rsp_valid=1 with stable payload until rsp_ready. Then go to IDLE; rsp_valid drops next cycle.
  - cmd_ready=0 while in RSP.
- Minimum latency, zero-wait slave with rsp_ready=1:
  - Write: cmd accept cycle N; aw/w handshake N+1; bvalid sampled N+2; rsp_valid N+3.
  - Read: same timing (ar at N+1, r at N+2, rsp N+3).
  - Back-to-back throughput: one transaction per 4 cycles.
- Error responses (SLVERR/DECERR) are passed through unmodified. The block does not retry.
- cmd_* changes while not accepted are ignored. Latched values are never updated mid-transaction.

Test Plan:
- Write, zero-wait slave: cmd addr=0x30, wdata=0xDEADBEEF_01234567, wstrb=0xFF. Required: awaddr=0x30 and wdata on the bus cycle N+1; rsp_valid at N+3 with rsp_write=1, rsp_resp=0, rsp_rdata=0.
- Read: slave returns rdata=0x0000_0000_CAFE_F00D, rresp=0 for araddr=0x18. Required: rsp_rdata=0xCAFEF00D, rsp_write=0 at N+3.
- Skewed AW/W: awready delayed 3 cycles, wready immediate. Required: wvalid drops after 1 cycle; awvalid held 4 cycles with stable awaddr; bready asserted only after AW completes; single response.
- Backpressure:
  - Hold bvalid low 5 cycles with bresp=2'b10, then rsp_ready low 3 cycles. Required: rsp_valid held 4 cycles, rsp_resp=2'b10, cmd_ready=0 throughout.
  - A second cmd_valid issued meanwhile is accepted only after return to IDLE.
- Reset while in RD_DATA: arvalid completed, rvalid never comes, assert rst 1 cycle. Required: rready=0, rsp_valid=0, cmd_ready=0 during the reset cycle; cmd_ready=1 the cycle after rst deasserts; no spurious response.
- Back-to-back: 8 alternating write/read commands to 0x00..0x38 against a register-model slave. Required: read data equals prior write data per strobes; exactly 8 responses in order.
